// File: rtl/usb_phy_tx.sv
// USB PHY transmit serializer: SYNC, NRZI, bit stuffing, abort and EOP onto dp/dm.
// Optional macro USB_PHY_TX_LS_EN adds an ls input that swaps J/K for low speed.
module usb_phy_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
`ifdef USB_PHY_TX_LS_EN
   input  logic       ls,
`endif
   input  logic       tx_lp_sop,
   input  logic       tx_lp_eop,
   input  logic       tx_lp_valid,
   output logic       tx_lp_ready,
   input  logic [7:0] tx_lp_data,
   input  logic       tx_lp_cancle,
   output logic       dp,
   output logic       dm,
   output logic       tx_oe,
   output logic       tx_abort,
   output logic       tx_err
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_ABORT, S_EOP} state_t;

   state_t        state_reg;
   logic [DW-1:0] div_reg;
   logic [2:0]    bit_reg;
   logic [2:0]    ones_reg;
   logic [7:0]    hold_data_reg;
   logic          hold_full_reg;
   logic          hold_eop_reg;
   logic [6:0]    shift_reg;
   logic [2:0]    left_reg;
   logic          shift_last_reg;
   logic          eop_acc_reg;
   logic          cancel_reg;
   logic          line_j_reg;
   logic          ls_reg;
   logic          abort_reg;

   logic       ls_in;
   logic       in_pkt, accept, cancel_now, cancel_any, tick, take_new;
   logic       load_full, load_eop, dbit, data_j;
   logic [7:0] load_data;
   logic [2:0] ones_inc;

`ifdef USB_PHY_TX_LS_EN
   assign ls_in = ls;
`else
   assign ls_in = 1'b0;
`endif

   // j=1 means the line is in the J state; low speed inverts the pad polarity.
   function automatic logic [1:0] line_sym(input logic j, input logic se0, input logic low_speed);
      if (se0)
         return 2'b00;
      return (j ^ low_speed) ? 2'b10 : 2'b01;
   endfunction

   assign in_pkt      = (state_reg == S_SYNC) || (state_reg == S_DATA);
   assign tx_lp_ready = (state_reg == S_IDLE) ||
                        (in_pkt && !hold_full_reg && !eop_acc_reg && !cancel_reg);
   assign accept      = tx_lp_valid && tx_lp_ready;
   assign cancel_now  = tx_lp_cancle && in_pkt && !cancel_reg;
   assign cancel_any  = cancel_now || cancel_reg;
   assign tick        = (div_reg == DIV_LAST);
   assign take_new    = accept && in_pkt && !cancel_now;
   assign tx_abort    = abort_reg || cancel_now;

   // A byte arriving exactly on a byte boundary bypasses the holding register.
   assign load_full = hold_full_reg || take_new;
   assign load_data = hold_full_reg ? hold_data_reg : tx_lp_data;
   assign load_eop  = hold_full_reg ? hold_eop_reg : tx_lp_eop;
   assign dbit      = (left_reg != 3'd0) ? shift_reg[0] : load_data[0];
   assign data_j    = dbit ? line_j_reg : ~line_j_reg;
   assign ones_inc  = dbit ? ones_reg + 3'd1 : 3'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         div_reg        <= '0;
         bit_reg        <= 3'd0;
         ones_reg       <= 3'd0;
         hold_data_reg  <= 8'd0;
         hold_full_reg  <= 1'b0;
         hold_eop_reg   <= 1'b0;
         shift_reg      <= 7'd0;
         left_reg       <= 3'd0;
         shift_last_reg <= 1'b0;
         eop_acc_reg    <= 1'b0;
         cancel_reg     <= 1'b0;
         line_j_reg     <= 1'b1;
         ls_reg         <= ls_in;
         {dp, dm}       <= line_sym(1'b1, 1'b0, ls_in);
         tx_oe          <= 1'b0;
         abort_reg      <= 1'b0;
         tx_err         <= 1'b0;
      end else begin
         abort_reg <= 1'b0;
         tx_err    <= 1'b0;
         div_reg   <= tick ? '0 : div_reg + DW'(1);

         if (cancel_now) begin
            cancel_reg    <= 1'b1;
            hold_full_reg <= 1'b0;
         end else if (take_new) begin
            hold_data_reg <= tx_lp_data;
            hold_eop_reg  <= tx_lp_eop;
            hold_full_reg <= 1'b1;
            if (tx_lp_eop)
               eop_acc_reg <= 1'b1;
            if (tx_lp_sop)
               tx_err <= 1'b1;
         end

         case (state_reg)
            S_IDLE: begin
               ls_reg        <= ls_in;
               line_j_reg    <= 1'b1;
               {dp, dm}      <= line_sym(1'b1, 1'b0, ls_in);
               tx_oe         <= 1'b0;
               cancel_reg    <= 1'b0;
               eop_acc_reg   <= 1'b0;
               hold_full_reg <= 1'b0;
               if (accept) begin
                  if (tx_lp_sop) begin
                     state_reg      <= S_SYNC;
                     div_reg        <= '0;
                     bit_reg        <= 3'd0;
                     ones_reg       <= 3'd0;
                     left_reg       <= 3'd0;
                     shift_last_reg <= 1'b0;
                     hold_data_reg  <= tx_lp_data;
                     hold_eop_reg   <= tx_lp_eop;
                     hold_full_reg  <= 1'b1;
                     eop_acc_reg    <= tx_lp_eop;
                     line_j_reg     <= 1'b0;
                     {dp, dm}       <= line_sym(1'b0, 1'b0, ls_in);
                     tx_oe          <= 1'b1;
                  end else begin
                     tx_err <= 1'b1;
                  end
               end
            end
            S_SYNC, S_DATA: if (tick) begin
               // Priority at a bit boundary: cancel, SYNC pattern, stuff, data, end of packet, underrun.
               if (cancel_any) begin
                  state_reg     <= S_ABORT;
                  bit_reg       <= 3'd0;
                  hold_full_reg <= 1'b0;
               end else if ((state_reg == S_SYNC) && (bit_reg != 3'd7)) begin
                  bit_reg <= bit_reg + 3'd1;
                  if (bit_reg == 3'd6) begin
                     ones_reg <= 3'd1;
                  end else begin
                     line_j_reg <= ~line_j_reg;
                     {dp, dm}   <= line_sym(~line_j_reg, 1'b0, ls_reg);
                  end
               end else if (ones_reg == 3'd6) begin
                  line_j_reg <= ~line_j_reg;
                  {dp, dm}   <= line_sym(~line_j_reg, 1'b0, ls_reg);
                  ones_reg   <= 3'd0;
               end else if (left_reg != 3'd0) begin
                  line_j_reg <= data_j;
                  {dp, dm}   <= line_sym(data_j, 1'b0, ls_reg);
                  ones_reg   <= ones_inc;
                  shift_reg  <= {1'b0, shift_reg[6:1]};
                  left_reg   <= left_reg - 3'd1;
               end else if (shift_last_reg) begin
                  state_reg <= S_EOP;
                  bit_reg   <= 3'd0;
                  {dp, dm}  <= 2'b00;
               end else if (load_full) begin
                  line_j_reg     <= data_j;
                  {dp, dm}       <= line_sym(data_j, 1'b0, ls_reg);
                  ones_reg       <= ones_inc;
                  shift_reg      <= load_data[7:1];
                  left_reg       <= 3'd7;
                  shift_last_reg <= load_eop;
                  hold_full_reg  <= 1'b0;
                  state_reg      <= S_DATA;
               end else begin
                  state_reg <= S_ABORT;
                  bit_reg   <= 3'd0;
                  abort_reg <= 1'b1;
               end
            end
            S_ABORT: if (tick) begin
               if (bit_reg == 3'd6) begin
                  state_reg <= S_EOP;
                  bit_reg   <= 3'd0;
                  {dp, dm}  <= 2'b00;
               end else begin
                  bit_reg <= bit_reg + 3'd1;
               end
            end
            S_EOP: if (tick) begin
               if (bit_reg == 3'd0) begin
                  bit_reg <= 3'd1;
               end else if (bit_reg == 3'd1) begin
                  bit_reg    <= 3'd2;
                  line_j_reg <= 1'b1;
                  {dp, dm}   <= line_sym(1'b1, 1'b0, ls_reg);
               end else begin
                  state_reg <= S_IDLE;
                  tx_oe     <= 1'b0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
